// File: rtl/motor_frame_engine.sv
// Multi-motor RS485 frame engine.
// Decodes setpoint, control-mode and status-request frames addressed to one of
// NUM_MOTORS register sets, checks CRC16 and ID, and replies to status requests.
//
// state | meaning
// HUNT  | scan rx bytes for a 4-byte magic
// RECV  | collect payload and CRC bytes, guard with inter-byte timeout
// CHECK | validate CRC/ID/motor and apply the frame
// BUILD | snapshot the 18-byte status reply
// SEND  | issue reply bytes to uart_tx
// DRAIN | wait for the last byte to finish, then release the driver
module motor_frame_engine #(
   parameter int          NUM_MOTORS     = 4,
   parameter int          DATA_W         = 24,
   parameter int          TIMEOUT_CYCLES = 50000,
   parameter logic [7:0]  BROADCAST_ID   = 8'hFF
) (
   input  logic                         CLK,
   input  logic                         reset_n,
   input  logic [7:0]                   ID,
   input  logic                         rx_valid,
   input  logic [7:0]                   rx_byte,
   output logic [7:0]                   tx_byte,
   output logic                         tx_start,
   input  logic                         tx_busy,
   output logic                         driver_enable,
   input  logic [NUM_MOTORS*DATA_W-1:0] position_flat,
   input  logic [NUM_MOTORS*DATA_W-1:0] duty_flat,
   output logic [NUM_MOTORS*DATA_W-1:0] setpoint_flat,
   output logic [NUM_MOTORS*8-1:0]      control_mode_flat,
   output logic [NUM_MOTORS-1:0]        setpoint_wr,
   output logic [15:0]                  crc_err_cnt,
   output logic [15:0]                  timeout_cnt,
   output logic                         frame_ok
);

   typedef enum logic [2:0] {HUNT, RECV, CHECK, BUILD, SEND, DRAIN} state_t;
   typedef enum logic [1:0] {K_STATUS, K_SETPOINT, K_MODE} kind_t;

   localparam logic [31:0] MAGIC_STATUS = 32'h1CE1CEBB;
   localparam logic [31:0] MAGIC_SP     = 32'hD0D0D0D0;
   localparam logic [31:0] MAGIC_MODE   = 32'hBAADA555;
   localparam logic [31:0] MAGIC_REPLY  = 32'h1CEB00DA;
   localparam int          TW           = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         fb = r[15] ^ d[i];
         r  = {r[14:0], 1'b0};
         if (fb) r = r ^ 16'h8005;
      end
      return r;
   endfunction

   state_t            state;
   kind_t             kind;
   logic [31:0]       magic_sr;
   logic [2:0]        rx_len;
   logic [2:0]        rx_idx;
   logic [7:0]        pl [7];
   logic [15:0]       crc_acc;
   logic [TW-1:0]     timer;
   logic [DATA_W-1:0] sp_reg [NUM_MOTORS];
   logic [7:0]        mode_reg [NUM_MOTORS];
   logic [7:0]        rbuf [18];
   logic [4:0]        tx_idx;
   logic              busy_q;

   logic [31:0]       magic_next;
   logic [15:0]       frame_crc;
   logic              crc_ok, motor_ok, id_ok;
   logic [DATA_W-1:0] sel_pos, sel_duty, sel_sp;
   logic [7:0]        sel_mode;
   logic [7:0]        rp [12];
   logic [15:0]       reply_crc;

   genvar g;
   generate
      for (g = 0; g < NUM_MOTORS; g++) begin : g_flat
         assign setpoint_flat[g*DATA_W +: DATA_W] = sp_reg[g];
         assign control_mode_flat[g*8 +: 8]      = mode_reg[g];
      end
   endgenerate

   // Frame validation terms used in CHECK
   always_comb begin
      magic_next = {magic_sr[23:0], rx_byte};
      case (kind)
         K_STATUS: frame_crc = {pl[2], pl[3]};
         K_MODE:   frame_crc = {pl[3], pl[4]};
         default:  frame_crc = {pl[5], pl[6]};
      endcase
      crc_ok   = (crc_acc == frame_crc);
      motor_ok = (int'(pl[1]) < NUM_MOTORS);
      if (kind == K_STATUS)
         id_ok = (pl[0] == ID) && (pl[0] != BROADCAST_ID);
      else
         id_ok = (pl[0] == ID) || (pl[0] == BROADCAST_ID);
   end

   // Per-motor selection and reply CRC for the status snapshot
   always_comb begin
      sel_pos  = '0;
      sel_duty = '0;
      sel_sp   = '0;
      sel_mode = '0;
      for (int m = 0; m < NUM_MOTORS; m++) begin
         if (pl[1] == 8'(m)) begin
            sel_pos  = position_flat[m*DATA_W +: DATA_W];
            sel_duty = duty_flat[m*DATA_W +: DATA_W];
            sel_sp   = sp_reg[m];
            sel_mode = mode_reg[m];
         end
      end
      rp[0]  = ID;
      rp[1]  = pl[1];
      rp[2]  = sel_mode;
      rp[3]  = sel_pos[23:16];
      rp[4]  = sel_pos[15:8];
      rp[5]  = sel_pos[7:0];
      rp[6]  = sel_duty[23:16];
      rp[7]  = sel_duty[15:8];
      rp[8]  = sel_duty[7:0];
      rp[9]  = sel_sp[23:16];
      rp[10] = sel_sp[15:8];
      rp[11] = sel_sp[7:0];
      reply_crc = 16'hFFFF;
      for (int i = 0; i < 12; i++) reply_crc = crc16_byte(reply_crc, rp[i]);
   end

   // Frame FSM with registered outputs
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state         <= HUNT;
         kind          <= K_STATUS;
         magic_sr      <= '0;
         rx_len        <= '0;
         rx_idx        <= '0;
         crc_acc       <= 16'hFFFF;
         timer         <= '0;
         tx_idx        <= '0;
         busy_q        <= 1'b0;
         tx_byte       <= '0;
         tx_start      <= 1'b0;
         driver_enable <= 1'b0;
         setpoint_wr   <= '0;
         frame_ok      <= 1'b0;
         crc_err_cnt   <= '0;
         timeout_cnt   <= '0;
         for (int i = 0; i < 7; i++)  pl[i]   <= '0;
         for (int i = 0; i < 18; i++) rbuf[i] <= '0;
         for (int m = 0; m < NUM_MOTORS; m++) begin
            sp_reg[m]   <= '0;
            mode_reg[m] <= '0;
         end
      end else begin
         tx_start    <= 1'b0;
         setpoint_wr <= '0;
         frame_ok    <= 1'b0;
         busy_q      <= tx_busy;
         case (state)
            HUNT: begin
               if (rx_valid) begin
                  magic_sr <= magic_next;
                  crc_acc  <= 16'hFFFF;
                  rx_idx   <= '0;
                  timer    <= TIMER_LOAD;
                  if (magic_next == MAGIC_STATUS) begin
                     kind <= K_STATUS; rx_len <= 3'd4; magic_sr <= '0; state <= RECV;
                  end else if (magic_next == MAGIC_SP) begin
                     kind <= K_SETPOINT; rx_len <= 3'd7; magic_sr <= '0; state <= RECV;
                  end else if (magic_next == MAGIC_MODE) begin
                     kind <= K_MODE; rx_len <= 3'd5; magic_sr <= '0; state <= RECV;
                  end
               end
            end
            RECV: begin
               if (rx_valid) begin
                  pl[rx_idx] <= rx_byte;
                  timer      <= TIMER_LOAD;
                  if (rx_idx < rx_len - 3'd2) crc_acc <= crc16_byte(crc_acc, rx_byte);
                  rx_idx <= rx_idx + 3'd1;
                  if (rx_idx == rx_len - 3'd1) state <= CHECK;
               end else if (timer == '0) begin
                  if (timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
                  state <= HUNT;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            CHECK: begin
               state <= HUNT;
               if (!crc_ok) begin
                  if (crc_err_cnt != 16'hFFFF) crc_err_cnt <= crc_err_cnt + 16'd1;
               end else if (motor_ok && id_ok) begin
                  frame_ok <= 1'b1;
                  case (kind)
                     K_SETPOINT: begin
                        for (int m = 0; m < NUM_MOTORS; m++) begin
                           if (pl[1] == 8'(m)) begin
                              sp_reg[m]      <= {pl[2], pl[3], pl[4]};
                              setpoint_wr[m] <= 1'b1;
                           end
                        end
                     end
                     K_MODE: begin
                        for (int m = 0; m < NUM_MOTORS; m++)
                           if (pl[1] == 8'(m)) mode_reg[m] <= pl[2];
                     end
                     default: state <= BUILD;
                  endcase
               end
            end
            BUILD: begin
               rbuf[0] <= MAGIC_REPLY[31:24];
               rbuf[1] <= MAGIC_REPLY[23:16];
               rbuf[2] <= MAGIC_REPLY[15:8];
               rbuf[3] <= MAGIC_REPLY[7:0];
               for (int i = 0; i < 12; i++) rbuf[4+i] <= rp[i];
               rbuf[16]      <= reply_crc[15:8];
               rbuf[17]      <= reply_crc[7:0];
               tx_idx        <= '0;
               driver_enable <= 1'b1;
               state         <= SEND;
            end
            SEND: begin
               // tx_start from the previous cycle blocks reissue until uart_tx raises busy
               if (!tx_busy && !tx_start) begin
                  tx_byte  <= rbuf[tx_idx];
                  tx_start <= 1'b1;
                  if (tx_idx == 5'd17) state <= DRAIN;
                  else tx_idx <= tx_idx + 5'd1;
               end
            end
            DRAIN: begin
               if (busy_q && !tx_busy) begin
                  driver_enable <= 1'b0;
                  state         <= HUNT;
               end
            end
            default: state <= HUNT;
         endcase
      end
   end

endmodule

// File: tb/tb_motor_frame_engine.sv
// Scoreboard bench for motor_frame_engine: stimulus pushes expected frame_ok
// and tx byte events, a negedge monitor pops and compares them.
module tb_motor_frame_engine;

   localparam int NM = 4;
   localparam int DW = 24;
   localparam int TO = 200;

   logic            CLK = 1'b0;
   logic            reset_n = 1'b0;
   logic [7:0]      ID = 8'h05;
   logic            rx_valid = 1'b0;
   logic [7:0]      rx_byte = '0;
   logic [7:0]      tx_byte;
   logic            tx_start;
   logic            tx_busy = 1'b0;
   logic            driver_enable;
   logic [NM*DW-1:0] position_flat;
   logic [NM*DW-1:0] duty_flat;
   logic [NM*DW-1:0] setpoint_flat;
   logic [NM*8-1:0]  control_mode_flat;
   logic [NM-1:0]    setpoint_wr;
   logic [15:0]      crc_err_cnt;
   logic [15:0]      timeout_cnt;
   logic             frame_ok;

   motor_frame_engine #(.NUM_MOTORS(NM), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .BROADCAST_ID(8'hFF)) dut (
      .CLK(CLK), .reset_n(reset_n), .ID(ID), .rx_valid(rx_valid), .rx_byte(rx_byte),
      .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy), .driver_enable(driver_enable),
      .position_flat(position_flat), .duty_flat(duty_flat), .setpoint_flat(setpoint_flat),
      .control_mode_flat(control_mode_flat), .setpoint_wr(setpoint_wr),
      .crc_err_cnt(crc_err_cnt), .timeout_cnt(timeout_cnt), .frame_ok(frame_ok)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit          is_tx;
      logic [7:0]  b;
      logic [3:0]  mask;
      logic [95:0] sp;
      logic [31:0] mode;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   int          n_tests = 0;
   int          n_fail = 0;
   int          tx_count = 0;
   int          busy_cnt = 0;
   logic [23:0] m_sp [NM];
   logic [7:0]  m_mode [NM];

   function automatic logic [15:0] crc16(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
         else r = {r[14:0], 1'b0};
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_fok(input logic [3:0] mask);
      exp_t e;
      e.is_tx = 1'b0; e.b = '0; e.mask = mask;
      for (int m = 0; m < NM; m++) begin
         e.sp[m*24 +: 24]  = m_sp[m];
         e.mode[m*8 +: 8]  = m_mode[m];
      end
      q.push_back(e);
   endtask

   task automatic push_tx(input logic [7:0] b);
      exp_t e;
      e.is_tx = 1'b1; e.b = b; e.mask = '0; e.sp = '0; e.mode = '0;
      q.push_back(e);
   endtask

   task automatic push_reply(input int m);
      logic [7:0]  r [18];
      logic [15:0] c;
      logic [23:0] p, d;
      p = position_flat[m*24 +: 24];
      d = duty_flat[m*24 +: 24];
      r[0] = 8'h1C; r[1] = 8'hEB; r[2] = 8'h00; r[3] = 8'hDA;
      r[4] = ID; r[5] = 8'(m); r[6] = m_mode[m];
      r[7] = p[23:16]; r[8] = p[15:8]; r[9] = p[7:0];
      r[10] = d[23:16]; r[11] = d[15:8]; r[12] = d[7:0];
      r[13] = m_sp[m][23:16]; r[14] = m_sp[m][15:8]; r[15] = m_sp[m][7:0];
      c = 16'hFFFF;
      for (int i = 4; i < 16; i++) c = crc16(c, r[i]);
      r[16] = c[15:8]; r[17] = c[7:0];
      for (int i = 0; i < 18; i++) push_tx(r[i]);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge CLK);
      rx_byte = b; rx_valid = 1'b1;
      @(negedge CLK);
      rx_valid = 1'b0;
      repeat (2) @(negedge CLK);
   endtask

   // payload is left-aligned in pl; n payload bytes, then CRC unless omitted
   task automatic send_frame(input logic [31:0] magic, input logic [55:0] pl, input int n,
                             input bit with_crc, input bit flip);
      logic [15:0] c;
      logic [7:0]  b;
      c = 16'hFFFF;
      for (int i = 0; i < 4; i++) send_byte(magic[31-8*i -: 8]);
      for (int i = 0; i < n; i++) begin
         b = pl[55-8*i -: 8];
         c = crc16(c, b);
         send_byte(b);
      end
      if (with_crc) begin
         if (flip) c = c ^ 16'h0100;
         send_byte(c[15:8]);
         send_byte(c[7:0]);
      end
      repeat (6) @(negedge CLK);
   endtask

   task automatic send_sp(input logic [7:0] id, input logic [7:0] m, input logic [23:0] sp, input bit flip);
      send_frame(32'hD0D0D0D0, {id, m, sp, 16'h0}, 5, 1'b1, flip);
   endtask

   task automatic send_mode(input logic [7:0] id, input logic [7:0] m, input logic [7:0] md);
      send_frame(32'hBAADA555, {id, m, md, 32'h0}, 3, 1'b1, 1'b0);
   endtask

   task automatic send_status(input logic [7:0] id, input logic [7:0] m);
      send_frame(32'h1CE1CEBB, {id, m, 40'h0}, 2, 1'b1, 1'b0);
   endtask

   task automatic wait_de(input logic lvl, input string name);
      int k;
      k = 0;
      while (driver_enable !== lvl && k < 2000) begin
         @(negedge CLK);
         k++;
      end
      chk(name, driver_enable, lvl);
   endtask

   // uart_tx model: busy for a few cycles after each tx_start
   always @(negedge CLK) begin
      if (tx_start) begin
         tx_busy  = 1'b1;
         busy_cnt = 5;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) tx_busy = 1'b0;
      end
   end

   // scoreboard monitor
   always @(negedge CLK) begin
      if (reset_n) begin
         if (frame_ok) begin
            if (q.size() == 0 || q[0].is_tx) begin
               n_tests++; n_fail++;
               $display("FAIL frame_ok_unexpected: got 1 expected 0");
            end else begin
               mon_e = q.pop_front();
               chk("setpoint_wr", setpoint_wr, mon_e.mask);
               chk("setpoint_flat", setpoint_flat, mon_e.sp);
               chk("control_mode_flat", control_mode_flat, mon_e.mode);
            end
         end else if (setpoint_wr != '0) begin
            n_tests++; n_fail++;
            $display("FAIL stray_setpoint_wr: got %0h expected 0", setpoint_wr);
         end
         if (tx_start) begin
            tx_count++;
            if (q.size() == 0 || !q[0].is_tx) begin
               n_tests++; n_fail++;
               $display("FAIL tx_start_unexpected: got byte %0h expected none", tx_byte);
            end else begin
               mon_e = q.pop_front();
               chk("tx_byte", tx_byte, mon_e.b);
               chk("driver_enable_during_tx", driver_enable, 1'b1);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   int tc0;

   initial begin
      position_flat = {24'hAAAAAA, 24'hBBBBBB, 24'h123456, 24'h111111};
      duty_flat     = {24'h0A0B0C, 24'h0D0E0F, 24'hFFFF00, 24'h222222};
      for (int m = 0; m < NM; m++) begin m_sp[m] = '0; m_mode[m] = '0; end
      repeat (3) @(negedge CLK);
      chk("reset_setpoint", setpoint_flat, 96'h0);
      chk("reset_mode", control_mode_flat, 32'h0);
      chk("reset_crc_err", crc_err_cnt, 16'h0);
      chk("reset_timeout", timeout_cnt, 16'h0);
      chk("reset_outputs", {tx_start, driver_enable, frame_ok, setpoint_wr, tx_byte}, '0);
      reset_n = 1'b1;
      repeat (3) @(negedge CLK);

      // setpoint to motor 2
      m_sp[2] = 24'h7FFFFF; push_fok(4'b0100);
      send_sp(8'h05, 8'd2, 24'h7FFFFF, 1'b0);

      // control mode on motor 1
      m_mode[1] = 8'h3C; push_fok(4'b0000);
      send_mode(8'h05, 8'd1, 8'h3C);

      // status request motor 1 -> 18 byte reply
      push_fok(4'b0000); push_reply(1);
      tc0 = tx_count;
      send_status(8'h05, 8'd1);
      wait_de(1'b1, "driver_enable_rise");
      wait_de(1'b0, "driver_enable_fall");
      chk("busy_low_at_release", tx_busy, 1'b0);
      chk("reply_len", tx_count - tc0, 18);
      chk("reply_drained", q.size(), 0);

      // corrupted CRC, then broadcast write, then broadcast status
      send_sp(8'h05, 8'd3, 24'h00ABCD, 1'b1);
      chk("crc_err_cnt", crc_err_cnt, 16'd1);
      m_sp[0] = 24'h800001; push_fok(4'b0001);
      send_sp(8'hFF, 8'd0, 24'h800001, 1'b0);
      send_status(8'hFF, 8'd0);
      repeat (40) @(negedge CLK);
      chk("broadcast_status_quiet", q.size(), 0);

      // inter-byte timeout then immediate valid frame
      send_frame(32'hD0D0D0D0, {8'h05, 8'h03, 8'h00, 32'h0}, 3, 1'b0, 1'b0);
      repeat (TO + 50) @(negedge CLK);
      chk("timeout_cnt", timeout_cnt, 16'd1);
      m_sp[3] = 24'h000123; push_fok(4'b1000);
      send_sp(8'h05, 8'd3, 24'h000123, 1'b0);

      // motor index out of range, and a magic-looking payload
      send_sp(8'h05, 8'd4, 24'h555555, 1'b0);
      send_frame(32'hD0D0D0D0, {8'hD0, 8'hD0, 24'hD0D0D0, 16'h0}, 5, 1'b1, 1'b0);
      m_sp[1] = 24'hD0D0D0; push_fok(4'b0010);
      send_sp(8'h05, 8'd1, 24'hD0D0D0, 1'b0);
      chk("counters_unchanged", {crc_err_cnt, timeout_cnt}, {16'd1, 16'd1});
      chk("setpoints_model", setpoint_flat, {m_sp[3], m_sp[2], m_sp[1], m_sp[0]});

      // reset in the middle of a reply
      push_fok(4'b0000); push_reply(2);
      tc0 = tx_count;
      send_status(8'h05, 8'd2);
      for (int k = 0; k < 500 && (tx_count - tc0) < 3; k++) @(negedge CLK);
      chk("reply_started", (tx_count - tc0) >= 3, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_tx_start", tx_start, 1'b0);
      chk("rst_driver_enable", driver_enable, 1'b0);
      chk("rst_setpoints", setpoint_flat, 96'h0);
      chk("rst_counters", {crc_err_cnt, timeout_cnt}, 32'h0);
      q.delete();
      for (int m = 0; m < NM; m++) begin m_sp[m] = '0; m_mode[m] = '0; end
      repeat (30) @(negedge CLK);
      reset_n = 1'b1;
      repeat (3) @(negedge CLK);
      m_sp[0] = 24'h000042; push_fok(4'b0001);
      send_sp(8'h05, 8'd0, 24'h000042, 1'b0);
      repeat (10) @(negedge CLK);
      chk("queue_empty_at_end", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/motor_frame_engine.md
Name: motor_frame_engine

Overview:
- Multi-motor successor to the single-motor RS485 command/status frame handler.
- Sits between the uart_rx/uart_tx byte streams and a bank of NUM_MOTORS per-motor register sets.
- Decodes setpoint, control-mode and status-request frames, each carrying a motor index, with CRC16 check and ID/broadcast filtering.
- Adds an inter-byte timeout, reply scheduling and error counters, none of which the single-motor handler has.

Parameters:
NUM_MOTORS, 4, number of motor channels (1..255)
DATA_W, 24, width of setpoint/position/duty fields; fixed at 3 bytes on the wire
TIMEOUT_CYCLES, 50000, max CLK cycles between rx bytes inside a frame before abort
BROADCAST_ID, 8'hFF, ID accepted by every board for write frames (never replied to)

Ports:
CLK  in  1  system clock
reset_n  in  1  async active-low reset
ID  in  8  board ID
rx_valid  in  1  one-cycle pulse, rx_byte valid
rx_byte  in  8  received byte
tx_byte  out  8  byte to transmit, held stable while tx_busy
tx_start  out  1  one-cycle transmit request
tx_busy  in  1  uart_tx active
driver_enable  out  1  RS485 driver enable
position_flat  in  NUM_MOTORS*DATA_W  per-motor position, motor m at [m*DATA_W +: DATA_W]
duty_flat  in  NUM_MOTORS*DATA_W  per-motor duty, same packing
setpoint_flat  out  NUM_MOTORS*DATA_W  per-motor signed setpoint
control_mode_flat  out  NUM_MOTORS*8  per-motor control mode
setpoint_wr  out  NUM_MOTORS  one-cycle pulse per motor when its setpoint is written
crc_err_cnt  out  16  saturating count of CRC failures
timeout_cnt  out  16  saturating count of inter-byte timeouts
frame_ok  out  1  one-cycle pulse per accepted frame

Behaviour:
- Reset (async, reset_n=0): state HUNT; all setpoints 0; all control modes 0; counters 0; tx_start, setpoint_wr, frame_ok, driver_enable 0; tx_byte 0; magic shift register cleared.
- Wire format: big-endian, 4-byte magic, then payload, then CRC hi, CRC lo.
  - Status request 1CE1CEBB: ID, motor, crc (4 payload bytes).
  - Setpoint D0D0D0D0: ID, motor, sp[23:16], sp[15:8], sp[7:0], crc (7).
  - Control mode BAADA555: ID, motor, mode, crc (5).
- CRC16: poly x^16+x^15+x^2+1, init FFFF, MSB-first, no reflection, no final xor. Computed over payload bytes after the magic, excluding the CRC; computed incrementally per received byte.
- FSM states:
  - HUNT: 4-byte shift register updates on rx_valid. On a magic match, go to RECV with the expected length; the shift register clears so the match cannot retrigger.
  - RECV: store a byte on each rx_valid. The inter-byte counter resets on each rx_valid. Counter reaches TIMEOUT_CYCLES -> timeout_cnt+1, go to HUNT. Last byte stored -> CHECK.
  - CHECK (1 cycle): the frame is accepted only if all of the following hold:
    - CRC matches.
    - motor < NUM_MOTORS.
    - ID matches, or ID==BROADCAST_ID for a write frame.
    - CRC fail -> crc_err_cnt+1 and HUNT. Any other rejection -> HUNT silently.
    - Accepted setpoint -> write setpoint[motor], pulse setpoint_wr[motor], pulse frame_ok, go to HUNT.
    - Accepted control mode -> write mode[motor], pulse frame_ok, go to HUNT.
    - Accepted status request (own ID only) -> pulse frame_ok, go to BUILD.
  - BUILD: snapshot an 18-byte reply into a buffer in one cycle: 1CEB00DA, ID, motor, mode[motor], position[motor] (3 bytes), duty[motor] (3 bytes), setpoint[motor] (3 bytes), CRC hi, CRC lo. The reply CRC covers bytes 4..15. Assert driver_enable, go to SEND.
  - SEND: present byte k on tx_byte and pulse tx_start. The next byte is issued only when tx_busy==0 and tx_start was not asserted the previous cycle. After the final byte, wait for tx_busy falling, deassert driver_enable the same cycle, go to HUNT.
- rx_valid during CHECK/BUILD/SEND is ignored; the shift register does not update (half-duplex).
- A magic pattern appearing inside a frame payload does not restart the frame.
- Counters saturate at FFFF.
- setpoint_wr and frame_ok are asserted in the same cycle the register updates.

Test Plan:
- Setpoint frame, ID=0x05, motor 2, sp=0x7FFFFF, valid CRC -> setpoint_flat[71:48]=7FFFFF, setpoint_wr=4'b0100 for 1 cycle, frame_ok, no tx_start.
- Status request, ID 0x05, motor 1, position[1]=0x123456, duty[1]=0xFFFF00 -> 18 tx_start pulses, bytes 1C EB 00 DA 05 01 mode 12 34 56 FF FF 00 sp.., CRC matching the bench model; driver_enable high from BUILD until tx_busy falls after byte 17.
- Setpoint with flipped CRC bit -> crc_err_cnt=1, no register change. Then broadcast ID FF setpoint to motor 0 -> written, no reply. Status request with ID FF -> ignored.
- Frame stalled after 3 payload bytes for TIMEOUT_CYCLES -> timeout_cnt=1, state HUNT. An immediately following valid frame is accepted.
- Motor index 4 with NUM_MOTORS=4 -> no write, no counter increment. Payload containing bytes D0 D0 D0 D0 -> no restart.
- reset_n low mid-SEND -> tx_start=0, driver_enable=0 immediately, all setpoints 0, counters 0.
